// File: rtl/regfile_commit_sequencer_if.sv
// Commit-side, RegFile write-port and lookup signals of the commit sequencer.
// master: the commit source / consumer (ROB side); slave: the sequencer itself.
interface regfile_commit_sequencer_if #(
  parameter int unsigned ROB_Entry_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH      = 4
);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

  // Commit lane 0 (older)
  logic                       C0_valid;
  logic [ROB_Entry_WIDTH-1:0] C0_ROBEN;
  logic [4:0]                 C0_DRindex;
  logic [31:0]                C0_Data;
  // Commit lane 1 (younger)
  logic                       C1_valid;
  logic [ROB_Entry_WIDTH-1:0] C1_ROBEN;
  logic [4:0]                 C1_DRindex;
  logic [31:0]                C1_Data;
  logic                       commit_ready;
  // RegFile write port
  logic [ROB_Entry_WIDTH-1:0] WP1_ROBEN;
  logic [4:0]                 WP1_DRindex;
  logic [31:0]                WP1_Data;
  // Pending-write lookup
  logic [4:0]                 LK_index;
  logic                       LK_hit;
  logic [ROB_Entry_WIDTH-1:0] LK_ROBEN;
  logic [31:0]                LK_Data;
  logic [CountW-1:0]          fifo_count;

  modport master (
    output C0_valid, C0_ROBEN, C0_DRindex, C0_Data,
    output C1_valid, C1_ROBEN, C1_DRindex, C1_Data,
    output LK_index,
    input  commit_ready, WP1_ROBEN, WP1_DRindex, WP1_Data,
    input  LK_hit, LK_ROBEN, LK_Data, fifo_count
  );

  modport slave (
    input  C0_valid, C0_ROBEN, C0_DRindex, C0_Data,
    input  C1_valid, C1_ROBEN, C1_DRindex, C1_Data,
    input  LK_index,
    output commit_ready, WP1_ROBEN, WP1_DRindex, WP1_Data,
    output LK_hit, LK_ROBEN, LK_Data, fifo_count
  );
endinterface

// File: rtl/regfile_commit_sequencer.sv
// Buffers up to two in-order ROB commits per cycle in a small FIFO and drains one
// write per cycle into the RegFile write port. Offers a combinational lookup of the
// youngest pending write to a register so readers can forward not-yet-written data.
module regfile_commit_sequencer #(
  parameter int unsigned ROB_Entry_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input logic                      clk,
  input logic                      rst,
  regfile_commit_sequencer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [ROB_Entry_WIDTH-1:0] roben;
    logic [4:0]                 dr;
    logic [31:0]                data;
  } entry_t;

  entry_t            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  entry_t            wp1_q, wp1_d;

  logic              ready;
  logic              enq0, enq1, deq;
  logic [1:0]        n_enq;
  logic              wr_a_en, wr_b_en;
  logic [PtrW-1:0]   wr_a_idx, wr_b_idx;
  entry_t            wr_a_entry, wr_b_entry;
  entry_t            lane0, lane1;

  logic                       lk_hit;
  logic [ROB_Entry_WIDTH-1:0] lk_roben;
  logic [31:0]                lk_data;
  logic [PtrW-1:0]            lk_idx;

  // Ready uses the pre-edge count only: a dequeue in the same edge does not help.
  assign ready = (count_q <= CntW'(FIFO_DEPTH - 2));

  assign lane0 = '{roben: bus.C0_ROBEN, dr: bus.C0_DRindex, data: bus.C0_Data};
  assign lane1 = '{roben: bus.C1_ROBEN, dr: bus.C1_DRindex, data: bus.C1_Data};

  // Enqueue/dequeue decisions, write slots and next pointer/count/WP1 state.
  always_comb begin
    enq0       = ready && bus.C0_valid && (bus.C0_DRindex != 5'd0);
    enq1       = ready && bus.C1_valid && (bus.C1_DRindex != 5'd0);
    deq        = (count_q != '0);
    n_enq      = {1'b0, enq0} + {1'b0, enq1};
    // C1 takes the slot after C0 when both land, otherwise the tail slot itself.
    wr_a_en    = enq0;
    wr_a_idx   = tail_q;
    wr_a_entry = lane0;
    wr_b_en    = enq1;
    wr_b_idx   = enq0 ? tail_q + PtrW'(1) : tail_q;
    wr_b_entry = lane1;
    tail_d     = tail_q + PtrW'(n_enq);
    head_d     = deq ? head_q + PtrW'(1) : head_q;
    count_d    = count_q + CntW'(n_enq) - CntW'(deq);
    wp1_d      = deq ? mem_q[head_q] : '0;
  end

  // Pointer, count and write-port stage; reset discards everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wp1_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wp1_q   <= wp1_d;
    end
  end

  // Storage array; stale contents are harmless because only head..tail-1 is ever read.
  always_ff @(posedge clk) begin
    if (wr_a_en) mem_q[wr_a_idx] <= wr_a_entry;
    if (wr_b_en) mem_q[wr_b_idx] <= wr_b_entry;
  end

  // Youngest-match lookup: scan WP1 first, then FIFO oldest to youngest so later hits win.
  always_comb begin
    lk_hit   = 1'b0;
    lk_roben = '0;
    lk_data  = '0;
    lk_idx   = '0;
    if (bus.LK_index != 5'd0) begin
      if ((wp1_q.roben != '0) && (wp1_q.dr == bus.LK_index)) begin
        lk_hit   = 1'b1;
        lk_roben = wp1_q.roben;
        lk_data  = wp1_q.data;
      end
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        lk_idx = head_q + PtrW'(i);
        if ((CntW'(i) < count_q) && (mem_q[lk_idx].dr == bus.LK_index)) begin
          lk_hit   = 1'b1;
          lk_roben = mem_q[lk_idx].roben;
          lk_data  = mem_q[lk_idx].data;
        end
      end
    end
  end

  assign bus.commit_ready = ready;
  assign bus.fifo_count   = count_q;
  assign bus.WP1_ROBEN    = wp1_q.roben;
  assign bus.WP1_DRindex  = wp1_q.dr;
  assign bus.WP1_Data     = wp1_q.data;
  assign bus.LK_hit       = lk_hit;
  assign bus.LK_ROBEN     = lk_roben;
  assign bus.LK_Data      = lk_data;

endmodule

// File: tb/tb_regfile_commit_sequencer.sv
// Directed bench for regfile_commit_sequencer: single commit, dual same-register
// commits with lookup, saturating dual stream, dropped DR0 lane, mid-cycle reset,
// and commits offered while not ready.
module tb_regfile_commit_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  regfile_commit_sequencer_if #(.ROB_Entry_WIDTH(5), .FIFO_DEPTH(4)) bus ();

  regfile_commit_sequencer #(.ROB_Entry_WIDTH(5), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_lanes();
    bus.C0_valid   = 1'b0;
    bus.C0_ROBEN   = '0;
    bus.C0_DRindex = '0;
    bus.C0_Data    = '0;
    bus.C1_valid   = 1'b0;
    bus.C1_ROBEN   = '0;
    bus.C1_DRindex = '0;
    bus.C1_Data    = '0;
  endtask

  task automatic drive_c0(input int rob, input int dr, input logic [31:0] d);
    bus.C0_valid = 1'b1; bus.C0_ROBEN = 5'(rob); bus.C0_DRindex = 5'(dr); bus.C0_Data = d;
  endtask

  task automatic drive_c1(input int rob, input int dr, input logic [31:0] d);
    bus.C1_valid = 1'b1; bus.C1_ROBEN = 5'(rob); bus.C1_DRindex = 5'(dr); bus.C1_Data = d;
  endtask

  task automatic test_reset();
    idle_lanes();
    bus.LK_index = 5'd5;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    total++;
    if (bus.fifo_count !== 3'd0 || bus.commit_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: count=%0d ready=%b, required count=0 ready=1",
               bus.fifo_count, bus.commit_ready);
    end
    total++;
    if (bus.WP1_ROBEN !== 5'd0 || bus.WP1_DRindex !== 5'd0 || bus.WP1_Data !== 32'd0 ||
        bus.LK_hit !== 1'b0) begin
      bad++;
      $display("FAIL reset_wp1: wp1=%0d/%0d/%h hit=%b, required 0/0/0 hit=0",
               bus.WP1_ROBEN, bus.WP1_DRindex, bus.WP1_Data, bus.LK_hit);
    end
  endtask

  task automatic test_single();
    drive_c0(3, 5, 32'hA5A5A5A5);
    bus.LK_index = 5'd5;
    tick();
    idle_lanes();
    total++;
    if (bus.fifo_count !== 3'd1 || bus.WP1_ROBEN !== 5'd0) begin
      bad++;
      $display("FAIL single_enq: count=%0d wp1=%0d, required count=1 wp1=0",
               bus.fifo_count, bus.WP1_ROBEN);
    end
    total++;
    if (bus.LK_hit !== 1'b1 || bus.LK_ROBEN !== 5'd3 || bus.LK_Data !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL single_lookup: hit=%b rob=%0d data=%h, required 1/3/a5a5a5a5",
               bus.LK_hit, bus.LK_ROBEN, bus.LK_Data);
    end
    tick();
    total++;
    if (bus.WP1_ROBEN !== 5'd3 || bus.WP1_DRindex !== 5'd5 || bus.WP1_Data !== 32'hA5A5A5A5 ||
        bus.fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL single_wp1: wp1=%0d/%0d/%h count=%0d, required 3/5/a5a5a5a5 count=0",
               bus.WP1_ROBEN, bus.WP1_DRindex, bus.WP1_Data, bus.fifo_count);
    end
    tick();
    total++;
    if (bus.WP1_ROBEN !== 5'd0 || bus.WP1_Data !== 32'd0) begin
      bad++;
      $display("FAIL single_idle: wp1=%0d data=%h, required 0/0", bus.WP1_ROBEN, bus.WP1_Data);
    end
  endtask

  task automatic test_same_reg();
    drive_c0(4, 7, 32'h11);
    drive_c1(5, 7, 32'h22);
    bus.LK_index = 5'd7;
    tick();
    idle_lanes();
    total++;
    if (bus.fifo_count !== 3'd2 || bus.LK_hit !== 1'b1 || bus.LK_ROBEN !== 5'd5 ||
        bus.LK_Data !== 32'h22) begin
      bad++;
      $display("FAIL samereg_both: count=%0d hit=%b rob=%0d data=%h, required 2/1/5/22",
               bus.fifo_count, bus.LK_hit, bus.LK_ROBEN, bus.LK_Data);
    end
    tick();
    total++;
    if (bus.WP1_ROBEN !== 5'd4 || bus.WP1_Data !== 32'h11 || bus.LK_ROBEN !== 5'd5 ||
        bus.LK_Data !== 32'h22) begin
      bad++;
      $display("FAIL samereg_first: wp1=%0d/%h lk=%0d/%h, required wp1=4/11 lk=5/22",
               bus.WP1_ROBEN, bus.WP1_Data, bus.LK_ROBEN, bus.LK_Data);
    end
    tick();
    total++;
    if (bus.WP1_ROBEN !== 5'd5 || bus.WP1_Data !== 32'h22 || bus.LK_hit !== 1'b1 ||
        bus.LK_ROBEN !== 5'd5) begin
      bad++;
      $display("FAIL samereg_second: wp1=%0d/%h hit=%b lk=%0d, required wp1=5/22 hit=1 lk=5",
               bus.WP1_ROBEN, bus.WP1_Data, bus.LK_hit, bus.LK_ROBEN);
    end
    tick();
    total++;
    if (bus.WP1_ROBEN !== 5'd0 || bus.LK_hit !== 1'b0 || bus.LK_ROBEN !== 5'd0) begin
      bad++;
      $display("FAIL samereg_done: wp1=%0d hit=%b lk=%0d, required 0/0/0",
               bus.WP1_ROBEN, bus.LK_hit, bus.LK_ROBEN);
    end
  endtask

  // Two commits whenever ready allows; scoreboard checks order, data and count bounds.
  task automatic test_back_to_back();
    int q[$];
    int next_rob;
    int n_sent;
    int seen;
    int cycles;
    int exp_rob;
    bit saw_not_ready;
    next_rob      = 8;
    n_sent        = 0;
    seen          = 0;
    cycles        = 0;
    saw_not_ready = 1'b0;
    bus.LK_index  = 5'd0;
    while (seen < 12 && cycles < 60) begin
      if (n_sent < 12 && bus.commit_ready === 1'b1) begin
        drive_c0(next_rob, next_rob, {4{8'(next_rob)}});
        drive_c1(next_rob + 1, next_rob + 1, {4{8'(next_rob + 1)}});
        q.push_back(next_rob);
        q.push_back(next_rob + 1);
        n_sent   += 2;
        next_rob += 2;
      end else begin
        idle_lanes();
      end
      tick();
      cycles++;
      if (bus.commit_ready === 1'b0) saw_not_ready = 1'b1;
      total++;
      if (bus.fifo_count > 3'd4 || bus.commit_ready !== (bus.fifo_count <= 3'd2)) begin
        bad++;
        $display("FAIL b2b_count: count=%0d ready=%b, required count<=4 and ready=(count<=2)",
                 bus.fifo_count, bus.commit_ready);
      end
      if (bus.WP1_ROBEN !== 5'd0) begin
        exp_rob = (q.size() > 0) ? q.pop_front() : 0;
        seen++;
        total++;
        if (bus.WP1_ROBEN !== 5'(exp_rob) || bus.WP1_DRindex !== 5'(exp_rob) ||
            bus.WP1_Data !== {4{8'(exp_rob)}}) begin
          bad++;
          $display("FAIL b2b_order: wp1=%0d/%0d/%h, required %0d/%0d/%h",
                   bus.WP1_ROBEN, bus.WP1_DRindex, bus.WP1_Data,
                   exp_rob, exp_rob, {4{8'(exp_rob)}});
        end
      end
    end
    idle_lanes();
    total++;
    if (seen != 12 || q.size() != 0 || !saw_not_ready) begin
      bad++;
      $display("FAIL b2b_complete: writes=%0d left=%0d ready_dropped=%b, required 12/0/1",
               seen, q.size(), saw_not_ready);
    end
    repeat (2) tick();
  endtask

  task automatic test_dr0_drop();
    drive_c0(2, 0, 32'hDEAD);
    drive_c1(6, 9, 32'h33);
    bus.LK_index = 5'd9;
    tick();
    idle_lanes();
    total++;
    if (bus.fifo_count !== 3'd1 || bus.LK_hit !== 1'b1 || bus.LK_ROBEN !== 5'd6 ||
        bus.LK_Data !== 32'h33) begin
      bad++;
      $display("FAIL dr0_enq: count=%0d hit=%b rob=%0d data=%h, required 1/1/6/33",
               bus.fifo_count, bus.LK_hit, bus.LK_ROBEN, bus.LK_Data);
    end
    bus.LK_index = 5'd0;
    #1;
    total++;
    if (bus.LK_hit !== 1'b0 || bus.LK_ROBEN !== 5'd0 || bus.LK_Data !== 32'd0) begin
      bad++;
      $display("FAIL dr0_lookup0: hit=%b rob=%0d data=%h, required 0/0/0",
               bus.LK_hit, bus.LK_ROBEN, bus.LK_Data);
    end
    tick();
    total++;
    if (bus.WP1_ROBEN !== 5'd6 || bus.WP1_DRindex !== 5'd9 || bus.fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL dr0_wp1: wp1=%0d/%0d count=%0d, required 6/9 count=0",
               bus.WP1_ROBEN, bus.WP1_DRindex, bus.fifo_count);
    end
    tick();
    total++;
    if (bus.WP1_ROBEN !== 5'd0) begin
      bad++;
      $display("FAIL dr0_idle: wp1=%0d, required 0 (dropped lane must not write)", bus.WP1_ROBEN);
    end
  endtask

  task automatic test_reset_mid();
    drive_c0(10, 1, 32'h100);
    drive_c1(11, 2, 32'h200);
    tick();
    drive_c0(12, 3, 32'h300);
    drive_c1(13, 4, 32'h400);
    tick();
    idle_lanes();
    total++;
    if (bus.fifo_count !== 3'd3 || bus.WP1_ROBEN !== 5'd10) begin
      bad++;
      $display("FAIL rstmid_pre: count=%0d wp1=%0d, required 3/10",
               bus.fifo_count, bus.WP1_ROBEN);
    end
    bus.LK_index = 5'd2;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.WP1_ROBEN !== 5'd0 || bus.WP1_Data !== 32'd0 || bus.fifo_count !== 3'd0 ||
        bus.commit_ready !== 1'b1 || bus.LK_hit !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_now: wp1=%0d data=%h count=%0d ready=%b hit=%b, required 0/0/0/1/0",
               bus.WP1_ROBEN, bus.WP1_Data, bus.fifo_count, bus.commit_ready, bus.LK_hit);
    end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.WP1_ROBEN !== 5'd0 || bus.fifo_count !== 3'd0) begin
        bad++;
        $display("FAIL rstmid_after: cycle=%0d wp1=%0d count=%0d, required 0/0",
                 i, bus.WP1_ROBEN, bus.fifo_count);
      end
    end
  endtask

  task automatic test_not_ready();
    drive_c0(14, 6, 32'h1400);
    drive_c1(15, 7, 32'h1500);
    tick();
    drive_c0(16, 6, 32'h1600);
    drive_c1(17, 9, 32'h1700);
    tick();
    total++;
    if (bus.commit_ready !== 1'b0 || bus.fifo_count !== 3'd3 || bus.WP1_ROBEN !== 5'd14) begin
      bad++;
      $display("FAIL nr_pre: ready=%b count=%0d wp1=%0d, required 0/3/14",
               bus.commit_ready, bus.fifo_count, bus.WP1_ROBEN);
    end
    drive_c0(20, 10, 32'h2000);
    drive_c1(21, 11, 32'h2100);
    if (bus.commit_ready === 1'b0)
      $display("protocol violation: lanes valid while commit_ready=0 (deliberate, must be ignored)");
    tick();
    idle_lanes();
    bus.LK_index = 5'd10;
    #1;
    total++;
    if (bus.fifo_count !== 3'd2 || bus.WP1_ROBEN !== 5'd15 || bus.LK_hit !== 1'b0) begin
      bad++;
      $display("FAIL nr_ignored: count=%0d wp1=%0d hit10=%b, required 2/15/0",
               bus.fifo_count, bus.WP1_ROBEN, bus.LK_hit);
    end
    bus.LK_index = 5'd6;
    #1;
    total++;
    if (bus.LK_hit !== 1'b1 || bus.LK_ROBEN !== 5'd16 || bus.LK_Data !== 32'h1600) begin
      bad++;
      $display("FAIL nr_lookup: hit=%b rob=%0d data=%h, required 1/16/1600",
               bus.LK_hit, bus.LK_ROBEN, bus.LK_Data);
    end
    tick();
    total++;
    if (bus.WP1_ROBEN !== 5'd16 || bus.LK_ROBEN !== 5'd16) begin
      bad++;
      $display("FAIL nr_wp1_16: wp1=%0d lk=%0d, required 16/16", bus.WP1_ROBEN, bus.LK_ROBEN);
    end
    tick();
    total++;
    if (bus.WP1_ROBEN !== 5'd17 || bus.WP1_DRindex !== 5'd9) begin
      bad++;
      $display("FAIL nr_wp1_17: wp1=%0d/%0d, required 17/9", bus.WP1_ROBEN, bus.WP1_DRindex);
    end
    tick();
    total++;
    if (bus.WP1_ROBEN !== 5'd0 || bus.fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL nr_drained: wp1=%0d count=%0d, required 0/0",
               bus.WP1_ROBEN, bus.fifo_count);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_lanes();
    bus.LK_index = '0;
    test_reset();
    test_single();
    test_same_reg();
    test_back_to_back();
    test_dr0_drop();
    test_reset_mid();
    test_not_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
